// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM arbiter.
//   DPRAM_DW / DPRAM_AW / DPRAM_NREQ / DPRAM_IDW : default data, address,
//   requester-count and requester-id widths.
//   req_t   : one requester's request {we, addr, wdata}.
//   cmd_t   : one RAM port command {we, addr, data, rd, id}.
//   make_cmd: builds a port command from a grant (all-zero when idle).
package dpram_pkg;

    localparam int DPRAM_DW   = 8;
    localparam int DPRAM_AW   = 6;
    localparam int DPRAM_NREQ = 4;
    localparam int DPRAM_IDW  = 2;

    typedef struct packed {
        logic                we;
        logic [DPRAM_AW-1:0] addr;
        logic [DPRAM_DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic                 we;
        logic [DPRAM_AW-1:0]  addr;
        logic [DPRAM_DW-1:0]  data;
        logic                 rd;
        logic [DPRAM_IDW-1:0] id;
    } cmd_t;

    // An idle port drives all-zero; read commands carry no write data.
    function automatic cmd_t make_cmd(input logic gnt, input logic [DPRAM_IDW-1:0] id,
                                      input req_t r);
        cmd_t c;
        c = '0;
        if (gnt) begin
            c.we   = r.we;
            c.addr = r.addr;
            c.data = r.we ? r.wdata : '0;
            c.rd   = ~r.we;
            c.id   = id;
        end
        return c;
    endfunction

endpackage

// File: rtl/dpram_arbiter_if.sv
// Requester-fabric bus of the dual-port RAM arbiter.
//   req_valid/req_we/req_addr/req_wdata : packed per-requester requests
//   req_ready                           : per-requester grant (combinational)
//   rsp_valid_x/rsp_id_x/rsp_data_x     : tagged read responses, one per RAM port
// Modports: master = requester fabric, slave = arbiter.
interface dpram_arbiter_if
    import dpram_pkg::*;
#(
    parameter int NREQ = DPRAM_NREQ,
    parameter int DW   = DPRAM_DW,
    parameter int AW   = DPRAM_AW,
    parameter int IDW  = DPRAM_IDW
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;

    logic               rsp_valid_a;
    logic [IDW-1:0]     rsp_id_a;
    logic [DW-1:0]      rsp_data_a;
    logic               rsp_valid_b;
    logic [IDW-1:0]     rsp_id_b;
    logic [DW-1:0]      rsp_data_b;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid_a, rsp_id_a, rsp_data_a,
        input  rsp_valid_b, rsp_id_b, rsp_data_b
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready,
        output rsp_valid_a, rsp_id_a, rsp_data_a,
        output rsp_valid_b, rsp_id_b, rsp_data_b
    );

endinterface

// File: rtl/dpram_rr_picker.sv
// Round-robin picker: first requester that is valid and not skipped,
// scanning upward from ptr with wrap modulo NREQ.
//   valid : request mask
//   ptr   : scan start position
//   skip  : requesters excluded from this pick
//   grant : one-hot winner (zero when nothing eligible)
//   id    : index of the winner (zero when nothing eligible)
module dpram_rr_picker
    import dpram_pkg::*;
#(
    parameter int NREQ = DPRAM_NREQ,
    parameter int IDW  = DPRAM_IDW
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic [NREQ-1:0] skip,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);

    logic [IDW-1:0] idx;
    logic           hit;

    always_comb begin
        grant = '0;
        id    = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            // NREQ is a power of two, so IDW-bit addition wraps for free.
            idx = ptr + IDW'(k);
            if (!hit && valid[idx] && !skip[idx]) begin
                hit        = 1'b1;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Dual-port RAM arbiter: grants up to two requests per cycle (port A then
// port B, round-robin), drives the RAM pins from registers and returns read
// data two cycles after acceptance on tagged per-port response channels.
//   clk, rst         : clock, asynchronous active-high reset
//   bus (slave)      : requester fabric requests, grants and responses
//   ram_addr_x/ram_data_x/ram_we_x : registered RAM port command
//   ram_q_x          : RAM read data (registered inside the RAM)
// Struct field widths follow dpram_pkg; change widths there.
module dpram_arbiter
    import dpram_pkg::*;
#(
    parameter int DW   = DPRAM_DW,
    parameter int AW   = DPRAM_AW,
    parameter int NREQ = DPRAM_NREQ,
    parameter int IDW  = DPRAM_IDW
) (
    input  logic            clk,
    input  logic            rst,
    dpram_arbiter_if.slave  bus,
    output logic [AW-1:0]   ram_addr_a,
    output logic [AW-1:0]   ram_addr_b,
    output logic [DW-1:0]   ram_data_a,
    output logic [DW-1:0]   ram_data_b,
    output logic            ram_we_a,
    output logic            ram_we_b,
    input  logic [DW-1:0]   ram_q_a,
    input  logic [DW-1:0]   ram_q_b
);

    req_t            req [NREQ];
    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] gnt_a, gnt_b, conflict, skip_b;
    logic [IDW-1:0]  id_a, id_b;
    logic            any_a, any_b;
    cmd_t            cmd_a_p0, cmd_b_p0;
    cmd_t            cmd_a_p1, cmd_b_p1;
    logic            vld_a_p2, vld_b_p2;
    logic [IDW-1:0]  id_a_p2, id_b_p2;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req[i].we    = bus.req_we[i];
            req[i].addr  = bus.req_addr[i*AW +: AW];
            req[i].wdata = bus.req_wdata[i*DW +: DW];
        end
    end

    dpram_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick_a (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .skip  ('0),
        .grant (gnt_a),
        .id    (id_a)
    );

    // Same address with at least one write cannot share a cycle with A;
    // read/read to the same address is harmless.
    always_comb begin
        conflict = '0;
        for (int i = 0; i < NREQ; i++) begin
            conflict[i] = (req[i].addr == req[id_a].addr) && (req[i].we || req[id_a].we);
        end
    end

    assign skip_b = gnt_a | conflict;

    // B scans from the same pointer; with A excluded, whatever it finds lies
    // after A in scan order.
    dpram_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick_b (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .skip  (skip_b),
        .grant (gnt_b),
        .id    (id_b)
    );

    assign any_a         = |gnt_a;
    assign any_b         = |gnt_b;
    assign bus.req_ready = (gnt_a | gnt_b) & {NREQ{~rst}};
    assign cmd_a_p0      = make_cmd(any_a, id_a, req[id_a]);
    assign cmd_b_p0      = make_cmd(any_b, id_b, req[id_b]);

    // ---- stage 1: accepted grants -> registered RAM command ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_a_p1 <= '0;
            cmd_b_p1 <= '0;
            rr_ptr   <= '0;
        end else begin
            cmd_a_p1 <= cmd_a_p0;
            cmd_b_p1 <= cmd_b_p0;
            if (any_a) begin
                rr_ptr <= id_a + IDW'(1);
            end
        end
    end

    assign ram_addr_a = cmd_a_p1.addr;
    assign ram_data_a = cmd_a_p1.data;
    assign ram_we_a   = cmd_a_p1.we;
    assign ram_addr_b = cmd_b_p1.addr;
    assign ram_data_b = cmd_b_p1.data;
    assign ram_we_b   = cmd_b_p1.we;

    // ---- stage 2: RAM access in progress; carry read tag ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_a_p2 <= 1'b0;
            vld_b_p2 <= 1'b0;
            id_a_p2  <= '0;
            id_b_p2  <= '0;
        end else begin
            vld_a_p2 <= cmd_a_p1.rd;
            vld_b_p2 <= cmd_b_p1.rd;
            id_a_p2  <= cmd_a_p1.id;
            id_b_p2  <= cmd_b_p1.id;
        end
    end

    // ---- stage 3: registered read response, one-cycle strobe ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid_a <= 1'b0;
            bus.rsp_id_a    <= '0;
            bus.rsp_data_a  <= '0;
            bus.rsp_valid_b <= 1'b0;
            bus.rsp_id_b    <= '0;
            bus.rsp_data_b  <= '0;
        end else begin
            bus.rsp_valid_a <= vld_a_p2;
            bus.rsp_id_a    <= vld_a_p2 ? id_a_p2 : '0;
            bus.rsp_data_a  <= vld_a_p2 ? ram_q_a : '0;
            bus.rsp_valid_b <= vld_b_p2;
            bus.rsp_id_b    <= vld_b_p2 ? id_b_p2 : '0;
            bus.rsp_data_b  <= vld_b_p2 ? ram_q_b : '0;
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Testbench for dpram_arbiter: bench-owned RAM, scan-order grant model and
// a response scoreboard keyed on cycle number.
module tb_dpram_arbiter;
    import dpram_pkg::*;

    localparam int N   = DPRAM_NREQ;
    localparam int AWL = DPRAM_AW;
    localparam int DWL = DPRAM_DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dpram_arbiter_if #(.NREQ(N), .DW(DWL), .AW(AWL), .IDW(DPRAM_IDW)) bus ();

    logic [AWL-1:0] ram_addr_a, ram_addr_b;
    logic [DWL-1:0] ram_data_a, ram_data_b, q_a, q_b;
    logic           ram_we_a, ram_we_b;

    dpram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_data_a (ram_data_a),
        .ram_data_b (ram_data_b),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_q_a    (q_a),
        .ram_q_b    (q_b)
    );

    // Dual-port RAM with registered read when not writing.
    logic [DWL-1:0] tb_mem [64];
    always @(posedge clk) begin
        if (ram_we_a) tb_mem[ram_addr_a] <= ram_data_a;
        else          q_a <= tb_mem[ram_addr_a];
        if (ram_we_b) tb_mem[ram_addr_b] <= ram_data_b;
        else          q_b <= tb_mem[ram_addr_b];
    end

    // Stimulus
    logic [N-1:0]   s_valid, s_we;
    logic [AWL-1:0] s_addr  [N];
    logic [DWL-1:0] s_wdata [N];

    always_comb begin
        bus.req_valid = s_valid;
        bus.req_we    = s_we;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AWL +: AWL]  = s_addr[i];
            bus.req_wdata[i*DWL +: DWL] = s_wdata[i];
        end
    end

    // Reference model state
    int             n_cmp = 0;
    int             n_err = 0;
    int             cyc = 0;
    int             m_ptr = 0;
    logic [DWL-1:0] m_mem [64];
    logic           ev_a [4], ev_b [4];
    logic [1:0]     eid_a [4], eid_b [4];
    logic [DWL-1:0] ed_a [4], ed_b [4];
    logic           pw_a, pw_b;
    logic [AWL-1:0] pa_a, pa_b;
    logic [DWL-1:0] pd_a, pd_b;
    logic [N-1:0]   obs_ready;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ev_a[i] = 1'b0; ev_b[i] = 1'b0;
        end
        pw_a = 1'b0; pa_a = '0; pd_a = '0;
        pw_b = 1'b0; pa_b = '0; pd_b = '0;
        m_ptr = 0;
    endtask

    task automatic idle();
        s_valid = '0;
        s_we    = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AWL-1:0] addr,
                           input logic [DWL-1:0] d);
        s_valid[i] = 1'b1;
        s_we[i]    = we;
        s_addr[i]  = addr;
        s_wdata[i] = d;
    endtask

    // One clock cycle: checks grants, responses and RAM command against the
    // model, then advances the model by the accepted requests.
    task automatic step();
        int         a, b, s;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        a = -1; b = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (s_valid[i]) begin
                if (a < 0) a = i;
                else if (b < 0 && !(s_addr[i] == s_addr[a] && (s_we[i] || s_we[a]))) b = i;
            end
        end
        exp_rdy = '0;
        if (a >= 0) exp_rdy[a] = 1'b1;
        if (b >= 0) exp_rdy[b] = 1'b1;
        n_cmp++;
        if (bus.req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, exp_rdy);
        end
        s = cyc % 4;
        n_cmp++;
        if (bus.rsp_valid_a !== ev_a[s]) begin
            n_err++;
            $display("FAIL rsp_valid_a cyc=%0d got=%b want=%b", cyc, bus.rsp_valid_a, ev_a[s]);
        end
        if (ev_a[s]) begin
            n_cmp++;
            if ({bus.rsp_id_a, bus.rsp_data_a} !== {eid_a[s], ed_a[s]}) begin
                n_err++;
                $display("FAIL rsp_a cyc=%0d got id=%0d data=%h want id=%0d data=%h",
                         cyc, bus.rsp_id_a, bus.rsp_data_a, eid_a[s], ed_a[s]);
            end
        end
        n_cmp++;
        if (bus.rsp_valid_b !== ev_b[s]) begin
            n_err++;
            $display("FAIL rsp_valid_b cyc=%0d got=%b want=%b", cyc, bus.rsp_valid_b, ev_b[s]);
        end
        if (ev_b[s]) begin
            n_cmp++;
            if ({bus.rsp_id_b, bus.rsp_data_b} !== {eid_b[s], ed_b[s]}) begin
                n_err++;
                $display("FAIL rsp_b cyc=%0d got id=%0d data=%h want id=%0d data=%h",
                         cyc, bus.rsp_id_b, bus.rsp_data_b, eid_b[s], ed_b[s]);
            end
        end
        ev_a[s] = 1'b0;
        ev_b[s] = 1'b0;
        n_cmp++;
        if ({ram_we_a, ram_addr_a, ram_we_b, ram_addr_b} !== {pw_a, pa_a, pw_b, pa_b}) begin
            n_err++;
            $display("FAIL ram_cmd cyc=%0d got we/addr a=%b/%h b=%b/%h want a=%b/%h b=%b/%h",
                     cyc, ram_we_a, ram_addr_a, ram_we_b, ram_addr_b, pw_a, pa_a, pw_b, pa_b);
        end
        if (pw_a || pw_b) begin
            n_cmp++;
            if ((pw_a && ram_data_a !== pd_a) || (pw_b && ram_data_b !== pd_b)) begin
                n_err++;
                $display("FAIL ram_wdata cyc=%0d got a=%h b=%h want a=%h b=%h",
                         cyc, ram_data_a, ram_data_b, pd_a, pd_b);
            end
        end
        // advance model with this cycle's accepted requests
        s = (cyc + 3) % 4;
        pw_a = 1'b0; pa_a = '0; pd_a = '0;
        pw_b = 1'b0; pa_b = '0; pd_b = '0;
        if (a >= 0) begin
            pw_a = s_we[a]; pa_a = s_addr[a]; pd_a = s_wdata[a];
            if (!s_we[a]) begin
                ev_a[s] = 1'b1; eid_a[s] = 2'(a); ed_a[s] = m_mem[s_addr[a]];
            end
        end
        if (b >= 0) begin
            pw_b = s_we[b]; pa_b = s_addr[b]; pd_b = s_wdata[b];
            if (!s_we[b]) begin
                ev_b[s] = 1'b1; eid_b[s] = 2'(b); ed_b[s] = m_mem[s_addr[b]];
            end
        end
        if (a >= 0 && s_we[a]) m_mem[s_addr[a]] = s_wdata[a];
        if (b >= 0 && s_we[b]) m_mem[s_addr[b]] = s_wdata[b];
        if (a >= 0) m_ptr = (a + 1) % N;
        obs_ready = bus.req_ready;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AWL'(i), '0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== '0) begin
            n_err++;
            $display("FAIL reset_ready got=%b want=0", bus.req_ready);
        end
        n_cmp++;
        if ({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_data_a, ram_data_b,
             bus.rsp_valid_a, bus.rsp_valid_b, bus.rsp_id_a, bus.rsp_id_b,
             bus.rsp_data_a, bus.rsp_data_b} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got nonzero want all 0");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        model_reset();
    endtask

    task automatic test_fill();
        for (int k = 0; k < 32; k++) begin
            idle();
            set_req(0, 1'b1, AWL'(2 * k), DWL'($urandom));
            set_req(1, 1'b1, AWL'(2 * k + 1), DWL'($urandom));
            step();
        end
        idle();
    endtask

    task automatic test_write_read();
        idle(); set_req(0, 1'b1, 6'h10, 8'h5A); step();
        idle(); set_req(0, 1'b0, 6'h10, 8'h00); step();
        idle(); step(); step();
        n_cmp++;
        if ({bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a} !== {1'b1, 2'd0, 8'h5A}) begin
            n_err++;
            $display("FAIL write_read got v=%b id=%0d d=%h want v=1 id=0 d=5a",
                     bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a);
        end
        step();
    endtask

    task automatic test_dual_grant();
        idle(); set_req(0, 1'b1, 6'h03, 8'h11); step();
        idle(); set_req(0, 1'b1, 6'h07, 8'h22); step();
        idle(); set_req(1, 1'b0, 6'h03, 8'h00); set_req(2, 1'b0, 6'h07, 8'h00); step();
        n_cmp++;
        if (obs_ready !== 4'b0110) begin
            n_err++;
            $display("FAIL dual_ready got=%b want=0110", obs_ready);
        end
        idle(); step(); step();
        n_cmp++;
        if ({bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a, bus.rsp_valid_b, bus.rsp_id_b,
             bus.rsp_data_b} !== {1'b1, 2'd1, 8'h11, 1'b1, 2'd2, 8'h22}) begin
            n_err++;
            $display("FAIL dual_rsp got a=%b/%0d/%h b=%b/%0d/%h want a=1/1/11 b=1/2/22",
                     bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a,
                     bus.rsp_valid_b, bus.rsp_id_b, bus.rsp_data_b);
        end
        step();
    endtask

    task automatic test_conflict();
        idle(); set_req(3, 1'b0, 6'h01, 8'h00); step();
        idle(); step(); step(); step();
        set_req(0, 1'b1, 6'h20, 8'hAA); set_req(1, 1'b1, 6'h20, 8'hBB); step();
        n_cmp++;
        if (obs_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL conflict_first got=%b want=0001", obs_ready);
        end
        idle(); set_req(1, 1'b1, 6'h20, 8'hBB); step();
        n_cmp++;
        if (obs_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL conflict_second got=%b want=0010", obs_ready);
        end
        idle(); set_req(2, 1'b0, 6'h20, 8'h00); step();
        idle(); step(); step();
        n_cmp++;
        if ({bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a} !== {1'b1, 2'd2, 8'hBB}) begin
            n_err++;
            $display("FAIL conflict_read got v=%b id=%0d d=%h want v=1 id=2 d=bb",
                     bus.rsp_valid_a, bus.rsp_id_a, bus.rsp_data_a);
        end
        step();
    endtask

    task automatic test_read_read();
        logic [DWL-1:0] want;
        want = m_mem[5];
        idle(); set_req(2, 1'b0, 6'h05, 8'h00); set_req(3, 1'b0, 6'h05, 8'h00); step();
        n_cmp++;
        if (obs_ready !== 4'b1100) begin
            n_err++;
            $display("FAIL readread_ready got=%b want=1100", obs_ready);
        end
        idle(); step(); step();
        n_cmp++;
        if ({bus.rsp_valid_a, bus.rsp_valid_b, bus.rsp_data_a, bus.rsp_data_b} !==
            {1'b1, 1'b1, want, want}) begin
            n_err++;
            $display("FAIL readread_rsp got v=%b%b a=%h b=%h want v=11 a=b=%h",
                     bus.rsp_valid_a, bus.rsp_valid_b, bus.rsp_data_a, bus.rsp_data_b, want);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        idle(); set_req(0, 1'b0, 6'h01, 8'h00); set_req(1, 1'b0, 6'h02, 8'h00); step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.req_ready, ram_we_a, ram_we_b, ram_addr_a, ram_addr_b} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs got ready=%b we=%b%b want all 0",
                     bus.req_ready, ram_we_a, ram_we_b);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc++;
        n_cmp++;
        if ({bus.rsp_valid_a, bus.rsp_valid_b} !== 2'b00) begin
            n_err++;
            $display("FAIL midreset_rsp0 got=%b%b want=00", bus.rsp_valid_a, bus.rsp_valid_b);
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AWL'(8 + i), 8'h00);
        step();
        n_cmp++;
        if (obs_ready !== 4'b0011) begin
            n_err++;
            $display("FAIL midreset_first_grant got=%b want=0011", obs_ready);
        end
        n_cmp++;
        if ({bus.rsp_valid_a, bus.rsp_valid_b} !== 2'b00) begin
            n_err++;
            $display("FAIL midreset_rsp1 got=%b%b want=00", bus.rsp_valid_a, bus.rsp_valid_b);
        end
        idle(); step(); step(); step();
    endtask

    task automatic test_fairness();
        int cnt [N];
        int wt [N];
        int max_wait;
        max_wait = 0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; wt[i] = 0;
            set_req(i, 1'b0, AWL'(6'h30 + i), 8'h00);
        end
        for (int c = 0; c < 8; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (obs_ready[i]) begin
                    cnt[i]++; wt[i] = 0;
                end else begin
                    wt[i]++;
                    if (wt[i] > max_wait) max_wait = wt[i];
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (cnt[i] < 3) begin
                n_err++;
                $display("FAIL fair_count req=%0d got=%0d want>=3", i, cnt[i]);
            end
        end
        n_cmp++;
        if (max_wait > 2) begin
            n_err++;
            $display("FAIL fair_wait got=%0d want<=2", max_wait);
        end
        idle(); step(); step(); step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                s_valid[i] = 1'($urandom);
                s_we[i]    = 1'($urandom);
                s_addr[i]  = AWL'($urandom_range(0, 7));
                s_wdata[i] = DWL'($urandom);
            end
            step();
        end
        idle(); step(); step(); step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        idle();
        for (int i = 0; i < N; i++) begin
            s_addr[i] = '0; s_wdata[i] = '0;
        end
        model_reset();
        test_reset();
        test_fill();
        test_write_read();
        test_dual_grant();
        test_conflict();
        test_read_read();
        test_reset_midstream();
        test_fairness();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Shares one dual-port RAM (8-bit data, 6-bit address, registered read when write-enable is low) among NREQ requesters.
- Each cycle it grants up to two requests using round-robin order, one on RAM port A and one on port B.
- Same-address conflicts are resolved by deferring one request.
- Read data returns to the requester on two tagged response channels, one per port.
- Sits between the requester fabric and the RAM; it drives the RAM pins directly.

Parameters:
- DW, 8, data width.
- AW, 6, address width.
- NREQ, 4, number of requesters (power of two, 2..8).
- IDW, 2, requester id width = log2(NREQ).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_ready  out  NREQ  combinational grant; a request is accepted when valid & ready at a rising edge.
- ram_addr_a, ram_addr_b  out  AW  RAM port addresses (registered).
- ram_data_a, ram_data_b  out  DW  RAM write data (registered).
- ram_we_a, ram_we_b  out  1  RAM write enables (registered).
- ram_q_a, ram_q_b  in  DW  RAM read data.
- rsp_valid_a, rsp_valid_b  out  1  one-cycle read-response strobe.
- rsp_id_a, rsp_id_b  out  IDW  requester id of the response.
- rsp_data_a, rsp_data_b  out  DW  read data (registered).

Behaviour:
- Reset (async, rst=1): all outputs 0, rr pointer 0, in-flight pipeline cleared.
  - Reads accepted before reset produce no response.
  - Reset mid-operation drops all in-flight reads.
  - req_ready is 0 while rst=1.
- Grant selection (combinational, each cycle):
  - Port A: first requester with valid=1, scanning from the rr pointer upward with wrap modulo NREQ.
  - Port B: next valid requester in the same scan order after A that does not conflict with A.
  - Conflict: same address and at least one of the two is a write. Read/read to the same address is not a conflict; both are granted.
  - Conflicting candidates are skipped for port B; the scan continues to the next candidate.
  - Only one valid requester: it goes to port A; port B is idle (we_b=0, addr_b=0, data_b=0).
  - No valid requester: both ports idle.
- rr pointer update: on any cycle with a port-A grant, pointer <= (A id + 1) mod NREQ; otherwise unchanged. Any persistently-valid requester is therefore granted within NREQ cycles.
- Stage 1 (edge E, grant accepted): ram_addr/data/we and per-port {rd, id} are registered. ram_we is 1 only for write grants.
- Stage 2 (edge E+1): the RAM performs the write or the read.
- Stage 3 (edge E+2): for reads, rsp_valid_x=1, rsp_id_x=id, rsp_data_x=ram_q_x; held for exactly one cycle.
  - Read latency is 2 cycles after acceptance.
  - Writes produce no response.
  - No response backpressure; requesters must always sink responses.
- Ordering and hazards:
  - A write accepted at edge E is committed at E+1, so a same-address read accepted at E+1 or later returns the new data.
  - A write/write conflict in the same cycle is serialized in scan order.
- Requests may change or drop while not ready; there is no hold requirement.
- Throughput: 2 accesses/cycle absent conflicts; fully pipelined.

Decomposition:
- Shared package dpram_pkg: DW, AW, NREQ, IDW defaults, plus a request struct {we, addr, wdata} and a port-command struct {we, addr, data, rd, id}.
- One sub-module, dpram_rr_picker: combinational rotate-and-priority-encode.
  - Inputs: valid mask, pointer, skip mask.
  - Outputs: one-hot grant and id.
  - Instantiated twice: once for port A, once for port B (mask = valid & ~A-grant & ~conflict).

Test Plan:
- Reset mid-stream: rst pulsed while 2 reads in flight -> no rsp_valid afterwards; all outputs 0; first grant after reset goes to req 0.
- Write/read: req0 writes 0x5A @ addr 0x10, then next cycle reads 0x10 -> rsp_valid_a 2 cycles after the read's acceptance, rsp_id_a=0, rsp_data_a=0x5A.
- Dual grant: req1 reads 0x03, req2 reads 0x07 (preloaded 0x11/0x22), pointer=1 -> same cycle: port A id1 data 0x11, port B id2 data 0x22.
- Conflict: req0 writes 0xAA @ 0x20 and req1 writes 0xBB @ 0x20 in the same cycle, pointer=0 -> req1 ready=0 that cycle, granted the next cycle; a subsequent read of 0x20 returns 0xBB.
- Read/read same address: req2 and req3 both read 0x05 -> both granted in the same cycle, both responses carry identical data.
- Fairness: all 4 requesters hold valid reads to distinct addresses for 8 cycles -> each granted ≥3 times, and no requester waits >2 cycles.
